// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - LC-3b shared types: word, extended-op encodings, divider states
package lc3b_types;

  localparam int WIDTH = 16;

  typedef logic [WIDTH-1:0] lc3b_word;
  typedef logic [2:0]       lc3b_op_x;

  // Extended ALU op select; divide encodings sit beside the multiplier's.
  localparam lc3b_op_x op_none = 3'b000;
  localparam lc3b_op_x op_mul  = 3'b001;
  localparam lc3b_op_x op_div  = 3'b010;
  localparam lc3b_op_x op_divu = 3'b011;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

  // Two's-complement negate when neg is set; 0x8000 wraps to itself.
  function automatic lc3b_word cond_negate(input lc3b_word v, input logic neg);
    lc3b_word n;
    n = lc3b_word'(~v + 1'b1);
    return neg ? n : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - start/busy/done request and hi/lo result bus of the divider
interface div_unit_if;
  import lc3b_types::*;

  logic     start;
  lc3b_op_x op_x_bits;
  lc3b_word opA;
  lc3b_word opB;
  logic     busy;
  logic     done;
  logic     div_by_zero;
  lc3b_word hi_bits;
  lc3b_word lo_bits;

  // Execute stage side: issues requests, consumes results.
  modport master (
    output start, op_x_bits, opA, opB,
    input  busy, done, div_by_zero, hi_bits, lo_bits
  );

  // Divider side.
  modport slave (
    input  start, op_x_bits, opA, opB,
    output busy, done, div_by_zero, hi_bits, lo_bits
  );

endinterface

// File: rtl/div_unit_step.sv
// rtl/div_unit_step.sv - one combinational restoring-division step
module div_step
  import lc3b_types::*;
(
  input  lc3b_word rem,
  input  lc3b_word quo,
  input  lc3b_word divisor,
  output lc3b_word next_rem,
  output lc3b_word next_quo
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  // Partial remainder shifted left with the next dividend bit brought in;
  // it can reach 17 bits when the divisor is above 0x7FFF.
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};
  assign fits    = (shifted >= {1'b0, divisor});

  // A fitting difference is always below the divisor, so 16 bits hold it.
  assign next_rem = lc3b_word'(fits ? diff : shifted);
  assign next_quo = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle 16-bit signed/unsigned restoring divider
module div_unit
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       reset_n,
  div_unit_if.slave  bus
);

  div_state_t state;

  // Captured request
  lc3b_word   a_q;
  lc3b_word   b_q;
  logic       is_signed;

  // Working registers; quo doubles as the dividend shift register.
  logic       sign_a;
  logic       sign_b;
  lc3b_word   rem;
  lc3b_word   quo;
  lc3b_word   divisor;
  logic [3:0] cnt;

  // Registered outputs
  logic       busy_q;
  logic       done_q;
  logic       dbz_q;
  lc3b_word   hi_q;
  lc3b_word   lo_q;

  lc3b_word   step_rem;
  lc3b_word   step_quo;
  logic       req_ok;

  assign req_ok = bus.start && (bus.op_x_bits == op_div || bus.op_x_bits == op_divu);

  div_step u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .next_rem (step_rem),
    .next_quo (step_quo)
  );

  // Control FSM with all datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      is_signed <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      rem       <= '0;
      quo       <= '0;
      divisor   <= '0;
      cnt       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (req_ok) begin
            a_q       <= bus.opA;
            b_q       <= bus.opB;
            is_signed <= (bus.op_x_bits == op_div);
            busy_q    <= 1'b1;
            state     <= PREP;
          end
        end

        PREP: begin
          if (b_q == '0) begin
            // Divide by zero: all-ones quotient, dividend returned untouched.
            lo_q   <= '1;
            hi_q   <= a_q;
            dbz_q  <= 1'b1;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            sign_a  <= is_signed & a_q[WIDTH-1];
            sign_b  <= is_signed & b_q[WIDTH-1];
            quo     <= cond_negate(a_q, is_signed & a_q[WIDTH-1]);
            divisor <= cond_negate(b_q, is_signed & b_q[WIDTH-1]);
            rem     <= '0;
            cnt     <= 4'd15;
            state   <= ITER;
          end
        end

        ITER: begin
          rem <= step_rem;
          quo <= step_quo;
          if (cnt == 4'd0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        FIX: begin
          // Quotient truncates toward zero; remainder follows the dividend sign.
          lo_q   <= cond_negate(quo, sign_a ^ sign_b);
          hi_q   <= cond_negate(rem, sign_a);
          dbz_q  <= 1'b0;
          done_q <= 1'b1;
          state  <= DONE;
        end

        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi_bits     = hi_q;
  assign bus.lo_bits     = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  div_unit_if bus ();

  div_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a request before the next edge; returns 1ns after that edge (E0).
  task automatic launch(input lc3b_op_x op, input lc3b_word a, input lc3b_word b);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.op_x_bits = op;
    bus.opA       = a;
    bus.opB       = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Edges after the call until done is seen; -1 if never within 40.
  task automatic wait_done(output int lat);
    int k;
    k   = 0;
    lat = -1;
    while (lat < 0 && k < 40) begin
      k++;
      @(posedge clk);
      #1;
      if (bus.done) lat = k;
    end
  endtask

  task automatic run(input string tag, input lc3b_op_x op, input lc3b_word a, input lc3b_word b,
                     input int exp_lat, input lc3b_word exp_lo, input lc3b_word exp_hi,
                     input logic exp_dbz);
    int lat;
    launch(op, a, b);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd1);
    check({tag, "_lo"}, 32'(bus.lo_bits), 32'(exp_lo));
    check({tag, "_hi"}, 32'(bus.hi_bits), 32'(exp_hi));
    check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(exp_dbz));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    check({tag, "_lo_held"}, 32'(bus.lo_bits), 32'(exp_lo));
  endtask

  initial begin
    int lat;
    int nd;
    int nb;

    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.op_x_bits = op_none;
    bus.opA       = '0;
    bus.opB       = '0;
    #12;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    check("rst_hi", 32'(bus.hi_bits), 32'd0);
    check("rst_lo", 32'(bus.lo_bits), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run("u100_7",   op_divu, 16'd100, 16'd7,  18, 16'h000E, 16'h0002, 1'b0);
    run("s_m7_2",   op_div,  16'hFFF9, 16'h0002, 18, 16'hFFFD, 16'hFFFF, 1'b0);
    run("u_fff9_2", op_divu, 16'hFFF9, 16'h0002, 18, 16'h7FFC, 16'h0001, 1'b0);
    run("s_7_m2",   op_div,  16'h0007, 16'hFFFE, 18, 16'hFFFD, 16'h0001, 1'b0);
    run("u_big_div", op_divu, 16'hFFFF, 16'h8001, 18, 16'h0001, 16'h7FFE, 1'b0);
    run("dbz",      op_div,  16'h1234, 16'h0000, 1,  16'hFFFF, 16'h1234, 1'b1);

    // Previous results and div_by_zero stay put until the next op's DONE.
    launch(op_divu, 16'd9, 16'd3);
    repeat (5) @(posedge clk);
    #1;
    check("hold_dbz", 32'(bus.div_by_zero), 32'd1);
    check("hold_lo", 32'(bus.lo_bits), 32'h0000FFFF);
    check("hold_hi", 32'(bus.hi_bits), 32'h00001234);
    wait_done(lat);
    check("after_dbz_lat", 32'(lat), 32'd13);
    check("after_dbz_lo", 32'(bus.lo_bits), 32'd3);
    check("after_dbz_hi", 32'(bus.hi_bits), 32'd0);
    check("after_dbz_clr", 32'(bus.div_by_zero), 32'd0);
    @(posedge clk);
    #1;

    run("s_8000_ffff", op_div, 16'h8000, 16'hFFFF, 18, 16'h8000, 16'h0000, 1'b0);

    // A start during ITER is dropped: one done, results of the first op.
    launch(op_divu, 16'd100, 16'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.op_x_bits = op_divu;
    bus.opA       = 16'd50;
    bus.opB       = 16'd5;
    @(negedge clk);
    bus.start = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) nd++;
    end
    check("busy_ign_ndone", 32'(nd), 32'd1);
    check("busy_ign_lo", 32'(bus.lo_bits), 32'd14);
    check("busy_ign_hi", 32'(bus.hi_bits), 32'd2);

    // A multiply op with start in IDLE never wakes the divider.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.op_x_bits = op_mul;
    bus.opA       = 16'd6;
    bus.opB       = 16'd3;
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.busy || bus.done) nb++;
    end
    bus.start = 1'b0;
    check("mul_ignored", 32'(nb), 32'd0);

    // Reset mid-ITER clears everything and the aborted op never completes.
    launch(op_divu, 16'd100, 16'd7);
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_lo", 32'(bus.lo_bits), 32'd0);
    check("mid_rst_hi", 32'(bus.hi_bits), 32'd0);
    check("mid_rst_dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) nd++;
    end
    check("rst_no_done", 32'(nd), 32'd0);

    run("u9_3", op_divu, 16'd9, 16'd3, 18, 16'd3, 16'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
